// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multicycle control sequencer
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_BREAK = 6'h0D;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_RTE   = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [3:0] ALU_PASS_A = 4'd0;
    localparam logic [3:0] ALU_NO_OP  = ALU_PASS_A;
    localparam logic [3:0] ALU_ADD    = 4'd1;
    localparam logic [3:0] ALU_SUB    = 4'd2;
    localparam logic [3:0] ALU_AND    = 4'd3;
    localparam logic [3:0] ALU_SLT    = 4'd4;
    localparam logic [3:0] ALU_SHIFT_LL = 4'd5;
    localparam logic [3:0] ALU_SHIFT_RL = 4'd6;
    localparam logic [3:0] ALU_SHIFT_RA = 4'd7;

    typedef enum logic [2:0] {
        ST_RESET, ST_FETCH, ST_DECODE, ST_EXEC, ST_FU_WAIT, ST_WB, ST_EXC, ST_HALT
    } state_t;

    localparam logic [2:0] PC_ALU    = 3'b000;
    localparam logic [2:0] PC_ALUOUT = 3'b001;
    localparam logic [2:0] PC_JUMP   = 3'b010;
    localparam logic [2:0] PC_EPC    = 3'b011;
    localparam logic [2:0] PC_VEC    = 3'b100;

    localparam logic [1:0] MEM_PC  = 2'b00;
    localparam logic [1:0] MEM_VEC = 2'b01;

    localparam logic [1:0] SRC_A_PC   = 2'b00;
    localparam logic [1:0] SRC_A_REG  = 2'b01;
    localparam logic [1:0] SRC_B_REG  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b11;

    localparam logic [2:0] DSEL_ALUOUT = 3'b000;
    localparam logic [2:0] DSEL_HI     = 3'b011;
    localparam logic [2:0] DSEL_LO     = 3'b100;
    localparam logic [2:0] DSEL_PC     = 3'b101;

    localparam logic [1:0] EXC_INV     = 2'b00;
    localparam logic [1:0] EXC_OVF     = 2'b01;
    localparam logic [1:0] EXC_DIV0    = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT = 2'b11;

    typedef enum logic [3:0] {
        CL_ALU, CL_SHIFT, CL_ADDI, CL_J, CL_JAL, CL_JR, CL_RTE,
        CL_BREAK, CL_MULT, CL_DIV, CL_MFHI, CL_MFLO, CL_INVALID
    } inst_class_t;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational opcode/funct to instruction class and ALU op
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output inst_class_t cls,
    output logic [3:0]  alu_op,
    output logic        ovf_chk,
    output logic        invalid
);

    always_comb begin
        cls     = CL_INVALID;
        alu_op  = ALU_NO_OP;
        ovf_chk = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:   begin cls = CL_ALU;   alu_op = ALU_ADD; ovf_chk = 1'b1; end
                    FN_SUB:   begin cls = CL_ALU;   alu_op = ALU_SUB; ovf_chk = 1'b1; end
                    FN_AND:   begin cls = CL_ALU;   alu_op = ALU_AND; end
                    FN_SLT:   begin cls = CL_ALU;   alu_op = ALU_SLT; end
                    FN_SLL:   begin cls = CL_SHIFT; alu_op = ALU_SHIFT_LL; end
                    FN_SRL:   begin cls = CL_SHIFT; alu_op = ALU_SHIFT_RL; end
                    FN_SRA:   begin cls = CL_SHIFT; alu_op = ALU_SHIFT_RA; end
                    FN_JR:    cls = CL_JR;
                    FN_MULT:  cls = CL_MULT;
                    FN_DIV:   cls = CL_DIV;
                    FN_MFHI:  cls = CL_MFHI;
                    FN_MFLO:  cls = CL_MFLO;
                    FN_RTE:   cls = CL_RTE;
                    FN_BREAK: cls = CL_BREAK;
                    default:  cls = CL_INVALID;
                endcase
            end
            OP_ADDI: begin cls = CL_ADDI; alu_op = ALU_ADD; ovf_chk = 1'b1; end
            OP_J:    cls = CL_J;
            OP_JAL:  cls = CL_JAL;
            default: cls = CL_INVALID;
        endcase
    end

    assign invalid = (cls == CL_INVALID);

endmodule

// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - multicycle control sequencer; FU_TIMEOUT_EN enables the mult/div watchdog
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int SHIFT_LAT  = 2,
    parameter int CNT_W      = 4,
    parameter int FU_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset_in,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       overflow,
    input  logic       fu_done,
    input  logic       fu_div0,
    output logic       reset_out,
    output logic       ir_w,
    output logic       pc_w,
    output logic [2:0] pc_src,
    output logic [1:0] mem_sel,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic       alu_out_w,
    output logic       ab_w,
    output logic       rf_w,
    output logic [1:0] rf_dst,
    output logic [2:0] rf_dsel,
    output logic       fu_start,
    output logic       fu_op,
    output logic       hilo_w,
    output logic       epc_w,
    output logic [1:0] exc_code,
    output logic       halted
);

    localparam logic [CNT_W-1:0] MEM_LAST   = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_LAT - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(FU_TIMEOUT - 1);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    inst_class_t        cls, cls_nx, dec_cls;
    logic [3:0]         op_q, op_nx, dec_op;
    logic               ovf_q, ovf_nx, dec_ovf, dec_inv;
    logic               fin, fin_nx;
    logic [1:0]         code_nx;

    mc_decode u_decode (
        .opcode  (opcode),
        .funct   (funct),
        .cls     (dec_cls),
        .alu_op  (dec_op),
        .ovf_chk (dec_ovf),
        .invalid (dec_inv)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        cls_nx   = cls;
        op_nx    = op_q;
        ovf_nx   = ovf_q;
        fin_nx   = 1'b0;
        code_nx  = exc_code;
        case (state)
            ST_RESET: state_nx = ST_FETCH;
            ST_FETCH: begin
                if (cnt == MEM_LAST) state_nx = ST_DECODE;
                else                 cnt_nx = cnt + 1'b1;
            end
            ST_DECODE: begin
                cls_nx = dec_cls;
                op_nx  = dec_op;
                ovf_nx = dec_ovf;
                if (dec_inv) begin
                    state_nx = ST_EXC;
                    code_nx  = EXC_INV;
                end else begin
                    case (dec_cls)
                        CL_MFHI, CL_MFLO: state_nx = ST_WB;
                        CL_BREAK:         state_nx = ST_HALT;
                        default:          state_nx = ST_EXEC;
                    endcase
                end
            end
            ST_EXEC: begin
                case (cls)
                    CL_SHIFT: begin
                        if (cnt == SHIFT_LAST) state_nx = ST_WB;
                        else                   cnt_nx = cnt + 1'b1;
                    end
                    CL_ALU, CL_ADDI: begin
                        if (ovf_q && overflow) begin
                            state_nx = ST_EXC;
                            code_nx  = EXC_OVF;
                        end else begin
                            state_nx = ST_WB;
                        end
                    end
                    // cnt tracks cycles since fu_start, so it enters the wait at 1
                    CL_MULT, CL_DIV: begin
                        state_nx = ST_FU_WAIT;
                        cnt_nx   = CNT_W'(1);
                    end
                    default: state_nx = ST_FETCH;
                endcase
            end
            ST_FU_WAIT: begin
                if (fin) begin
                    state_nx = ST_FETCH;
                end else if (fu_done) begin
                    if (cls == CL_DIV && fu_div0) begin
                        state_nx = ST_EXC;
                        code_nx  = EXC_DIV0;
                    end else begin
                        fin_nx = 1'b1;
                    end
`ifdef FU_TIMEOUT_EN
                end else if (cnt == WAIT_LAST) begin
                    state_nx = ST_EXC;
                    code_nx  = EXC_TIMEOUT;
`endif
                end else begin
                    cnt_nx = (cnt == WAIT_LAST) ? cnt : cnt + 1'b1;
                end
            end
            ST_WB: state_nx = ST_FETCH;
            ST_EXC: begin
                if (cnt == MEM_LAST) state_nx = ST_FETCH;
                else                 cnt_nx = cnt + 1'b1;
            end
            ST_HALT: state_nx = ST_HALT;
            default: state_nx = ST_RESET;
        endcase
    end

    // Outputs are a function of the state being entered, so every strobe is registered.
    always_ff @(posedge clk) begin
        reset_out <= 1'b0;
        ir_w      <= 1'b0;
        pc_w      <= 1'b0;
        pc_src    <= PC_ALU;
        mem_sel   <= MEM_PC;
        alu_src_a <= SRC_A_PC;
        alu_src_b <= SRC_B_REG;
        alu_op    <= ALU_NO_OP;
        alu_out_w <= 1'b0;
        ab_w      <= 1'b0;
        rf_w      <= 1'b0;
        rf_dst    <= DST_RT;
        rf_dsel   <= DSEL_ALUOUT;
        fu_start  <= 1'b0;
        fu_op     <= 1'b0;
        hilo_w    <= 1'b0;
        epc_w     <= 1'b0;
        halted    <= 1'b0;
        if (reset_in) begin
            state     <= ST_RESET;
            cnt       <= '0;
            cls       <= CL_INVALID;
            op_q      <= ALU_NO_OP;
            ovf_q     <= 1'b0;
            fin       <= 1'b0;
            exc_code  <= EXC_INV;
            reset_out <= 1'b1;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            cls      <= cls_nx;
            op_q     <= op_nx;
            ovf_q    <= ovf_nx;
            fin      <= fin_nx;
            exc_code <= code_nx;
            case (state_nx)
                ST_FETCH: begin
                    alu_src_b <= SRC_B_FOUR;
                    alu_op    <= ALU_ADD;
                    if (cnt_nx == MEM_LAST) begin
                        ir_w   <= 1'b1;
                        pc_w   <= 1'b1;
                        pc_src <= PC_ALU;
                    end
                end
                ST_DECODE: ab_w <= 1'b1;
                ST_EXEC: begin
                    case (cls_nx)
                        CL_ALU, CL_SHIFT: begin
                            alu_src_a <= SRC_A_REG;
                            alu_src_b <= SRC_B_REG;
                            alu_op    <= op_nx;
                            alu_out_w <= (cls_nx != CL_SHIFT) || (cnt_nx == SHIFT_LAST);
                        end
                        CL_ADDI: begin
                            alu_src_a <= SRC_A_REG;
                            alu_src_b <= SRC_B_IMM;
                            alu_op    <= op_nx;
                            alu_out_w <= 1'b1;
                        end
                        CL_J: begin
                            pc_w   <= 1'b1;
                            pc_src <= PC_JUMP;
                        end
                        CL_JAL: begin
                            pc_w    <= 1'b1;
                            pc_src  <= PC_JUMP;
                            rf_w    <= 1'b1;
                            rf_dst  <= DST_RA;
                            rf_dsel <= DSEL_PC;
                        end
                        CL_JR: begin
                            alu_src_a <= SRC_A_REG;
                            alu_op    <= ALU_PASS_A;
                            pc_w      <= 1'b1;
                            pc_src    <= PC_ALU;
                        end
                        CL_RTE: begin
                            pc_w   <= 1'b1;
                            pc_src <= PC_EPC;
                        end
                        CL_MULT, CL_DIV: begin
                            fu_start <= 1'b1;
                            fu_op    <= (cls_nx == CL_DIV);
                        end
                        default: ;
                    endcase
                end
                ST_FU_WAIT: hilo_w <= fin_nx;
                ST_WB: begin
                    rf_w    <= 1'b1;
                    rf_dst  <= (cls_nx == CL_ADDI) ? DST_RT : DST_RD;
                    rf_dsel <= (cls_nx == CL_MFHI) ? DSEL_HI :
                               (cls_nx == CL_MFLO) ? DSEL_LO : DSEL_ALUOUT;
                end
                ST_EXC: begin
                    if (cnt_nx == '0) begin
                        epc_w <= 1'b1;
                    end else begin
                        mem_sel <= MEM_VEC;
                        if (cnt_nx == MEM_LAST) begin
                            pc_w   <= 1'b1;
                            pc_src <= PC_VEC;
                        end
                    end
                end
                ST_HALT: halted <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_sequencer.sv
// tb/tb_mc_sequencer.sv - directed and randomized bench for mc_sequencer against a cycle-trace model
module tb_mc_sequencer;

    localparam int MEM_LAT   = 2;
    localparam int SHIFT_LAT = 2;

    logic       clk = 1'b0;
    logic       reset_in = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       overflow = 1'b0;
    logic       fu_done = 1'b0;
    logic       fu_div0 = 1'b0;
    logic       reset_out, ir_w, pc_w, alu_out_w, ab_w, rf_w, fu_start, fu_op, hilo_w, epc_w, halted;
    logic [2:0] pc_src, rf_dsel;
    logic [1:0] mem_sel, alu_src_a, alu_src_b, rf_dst, exc_code;
    logic [3:0] alu_op;

    mc_sequencer #(.MEM_LAT(MEM_LAT), .SHIFT_LAT(SHIFT_LAT), .CNT_W(4), .FU_TIMEOUT(15)) dut (
        .clk(clk), .reset_in(reset_in), .opcode(opcode), .funct(funct), .overflow(overflow),
        .fu_done(fu_done), .fu_div0(fu_div0), .reset_out(reset_out), .ir_w(ir_w), .pc_w(pc_w),
        .pc_src(pc_src), .mem_sel(mem_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .alu_out_w(alu_out_w), .ab_w(ab_w), .rf_w(rf_w), .rf_dst(rf_dst),
        .rf_dsel(rf_dsel), .fu_start(fu_start), .fu_op(fu_op), .hilo_w(hilo_w), .epc_w(epc_w),
        .exc_code(exc_code), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       reset_out, ir_w, pc_w;
        logic [2:0] pc_src;
        logic [1:0] mem_sel, alu_src_a, alu_src_b;
        logic [3:0] alu_op;
        logic       alu_out_w, ab_w, rf_w;
        logic [1:0] rf_dst;
        logic [2:0] rf_dsel;
        logic       fu_start, fu_op, hilo_w, epc_w;
        logic [1:0] exc_code;
        logic       halted;
    } ctl_t;

    ctl_t obs;
    always_comb obs = {reset_out, ir_w, pc_w, pc_src, mem_sel, alu_src_a, alu_src_b, alu_op,
                       alu_out_w, ab_w, rf_w, rf_dst, rf_dsel, fu_start, fu_op, hilo_w, epc_w,
                       exc_code, halted};

    localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_SLT = 3, K_SLL = 4, K_SRL = 5, K_SRA = 6;
    localparam int K_JR = 7, K_MULT = 8, K_DIV = 9, K_MFHI = 10, K_MFLO = 11, K_RTE = 12;
    localparam int K_BRK = 13, K_ADDI = 14, K_J = 15, K_JAL = 16, K_INV = 17;

    logic [5:0] t_opc [0:16] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h02, 6'h03};
    logic [5:0] t_fn  [0:16] = '{6'h20, 6'h22, 6'h24, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h08, 6'h18,
                                 6'h1A, 6'h10, 6'h12, 6'h11, 6'h0D, 6'h00, 6'h00, 6'h00};

    int   vectors = 0;
    int   miscompares = 0;
    logic [1:0] cur_exc = 2'b00;
    ctl_t exp_q[$];
    bit   done_q[$];

    function automatic int kind_of(logic [5:0] opc, logic [5:0] fn);
        if (opc == 6'h08) return K_ADDI;
        if (opc == 6'h02) return K_J;
        if (opc == 6'h03) return K_JAL;
        if (opc != 6'h00) return K_INV;
        for (int i = 0; i <= K_BRK; i++)
            if (t_fn[i] == fn) return i;
        return K_INV;
    endfunction

    function automatic ctl_t z();
        ctl_t c = '0;
        c.exc_code = cur_exc;
        return c;
    endfunction

    function automatic ctl_t rst_word();
        ctl_t c = '0;
        c.reset_out = 1'b1;
        return c;
    endfunction

    function automatic bit noise();
        return $urandom_range(0, 3) == 0;
    endfunction

    task automatic push(ctl_t c, bit d);
        exp_q.push_back(c);
        done_q.push_back(d);
    endtask

    task automatic push_exc(logic [1:0] code, bit d);
        ctl_t c;
        cur_exc = code;
        c = z(); c.epc_w = 1'b1; push(c, d);
        for (int i = 1; i <= MEM_LAT; i++) begin
            c = z(); c.mem_sel = 2'b01;
            if (i == MEM_LAT) begin c.pc_w = 1'b1; c.pc_src = 3'b100; end
            push(c, 1'b0);
        end
    endtask

    task automatic push_wb(logic [1:0] dst, logic [2:0] dsel);
        ctl_t c = z();
        c.rf_w = 1'b1; c.rf_dst = dst; c.rf_dsel = dsel;
        push(c, 1'b0);
    endtask

    // Expected per-cycle trace of one instruction, from FETCH to the cycle before the next FETCH.
    task automatic build(int kind, bit ovf, int d, bit div0);
        ctl_t c;
        int   n;
        for (int i = 0; i <= MEM_LAT; i++) begin
            c = z(); c.alu_src_b = 2'b01; c.alu_op = 4'd1;
            if (i == MEM_LAT) begin c.ir_w = 1'b1; c.pc_w = 1'b1; end
            push(c, i > 0 && noise());
        end
        c = z(); c.ab_w = 1'b1; push(c, noise());
        if (kind == K_INV) begin
            push_exc(2'b00, 1'b0);
        end else if (kind <= K_SRA) begin
            n = (kind >= K_SLL) ? SHIFT_LAT : 1;
            for (int j = 0; j < n; j++) begin
                c = z(); c.alu_src_a = 2'b01; c.alu_op = 4'(kind + 1); c.alu_out_w = (j == n - 1);
                push(c, 1'b0);
            end
            if ((kind == K_ADD || kind == K_SUB) && ovf) push_exc(2'b01, 1'b0);
            else                                         push_wb(2'b01, 3'b000);
        end else if (kind == K_ADDI) begin
            c = z(); c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.alu_op = 4'd1; c.alu_out_w = 1'b1;
            push(c, 1'b0);
            if (ovf) push_exc(2'b01, 1'b0);
            else     push_wb(2'b00, 3'b000);
        end else if (kind == K_J || kind == K_JAL) begin
            c = z(); c.pc_w = 1'b1; c.pc_src = 3'b010;
            if (kind == K_JAL) begin c.rf_w = 1'b1; c.rf_dst = 2'b11; c.rf_dsel = 3'b101; end
            push(c, 1'b0);
        end else if (kind == K_JR) begin
            c = z(); c.alu_src_a = 2'b01; c.alu_op = 4'd0; c.pc_w = 1'b1; c.pc_src = 3'b000;
            push(c, 1'b0);
        end else if (kind == K_RTE) begin
            c = z(); c.pc_w = 1'b1; c.pc_src = 3'b011; push(c, 1'b0);
        end else if (kind == K_MULT || kind == K_DIV) begin
            c = z(); c.fu_start = 1'b1; c.fu_op = (kind == K_DIV); push(c, 1'b0);
            for (int j = 1; j <= d; j++) push(z(), 1'b0);
            if (kind == K_DIV && div0) push_exc(2'b10, 1'b1);
            else begin c = z(); c.hilo_w = 1'b1; push(c, 1'b1); end
        end else if (kind == K_MFHI || kind == K_MFLO) begin
            push_wb(2'b01, (kind == K_MFHI) ? 3'b011 : 3'b100);
        end else begin
            for (int j = 0; j < 4; j++) begin c = z(); c.halted = 1'b1; push(c, 1'b0); end
        end
    endtask

    task automatic check(string tag, int idx, ctl_t expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s[%0d] observed %h expected %h", tag, idx, obs, expv);
        end
    endtask

    task automatic run(string tag, logic [5:0] opc, logic [5:0] fn, bit ovf, int d, bit div0,
                       int abort_at);
        opcode = opc; funct = fn; overflow = ovf; fu_div0 = div0;
        build(kind_of(opc, fn), ovf, d, div0);
        for (int k = 0; k < exp_q.size(); k++) begin
            fu_done = done_q[k];
            if (k == abort_at) reset_in = 1'b1;
            @(posedge clk); #1;
            if (k == abort_at) begin
                check({tag, "_abort"}, k, rst_word());
                cur_exc = 2'b00;
                break;
            end
            check(tag, k, exp_q[k]);
        end
        fu_done = 1'b0;
        exp_q.delete();
        done_q.delete();
    endtask

    task automatic do_reset(int n);
        reset_in = 1'b1; fu_done = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("reset", i, rst_word());
        end
        cur_exc = 2'b00;
        reset_in = 1'b0;
    endtask

    initial begin
        logic [5:0] opc, fn;
        int         pick;

        do_reset(3);
        run("add", 6'h00, 6'h20, 1'b0, 0, 1'b0, -1);
        run("addi_ovf", 6'h08, 6'h15, 1'b1, 0, 1'b0, -1);
        run("div0", 6'h00, 6'h1A, 1'b0, 10, 1'b1, -1);
        run("mult34", 6'h00, 6'h18, 1'b0, 34, 1'b0, -1);
        run("jal", 6'h03, 6'h00, 1'b0, 0, 1'b0, -1);
        run("op3d", 6'h3D, 6'h00, 1'b0, 0, 1'b0, -1);
        run("break", 6'h00, 6'h0D, 1'b0, 0, 1'b0, -1);
        do_reset(2);
        run("mult_rst", 6'h00, 6'h18, 1'b0, 34, 1'b0, MEM_LAT + 6);
        do_reset(2);

        for (int n = 0; n < 60; n++) begin
            pick = $urandom_range(0, 17);
            if (pick == K_BRK || pick == K_INV) begin
                do begin
                    opc = ($urandom_range(0, 1) == 0) ? 6'h00 : 6'($urandom);
                    fn  = 6'($urandom);
                end while (kind_of(opc, fn) != K_INV);
            end else begin
                opc = t_opc[pick];
                fn  = (opc != 6'h00) ? 6'($urandom) : t_fn[pick];
            end
            run("rand", opc, fn, 1'($urandom), $urandom_range(1, 12), 1'($urandom), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
